srsub_seq: RTL and testbench

//  Multi-cycle single-precision subtractor: z = a - b, any operand signs.

---
 rtl/srsub_seq.sv | 209 ++++++++++++++++++++
 tb/tb_srsub_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/srsub_seq.sv
// srsub_seq: multi-cycle IEEE single-precision subtractor z = a - b.
// Operands are latched with b's sign inverted, aligned, added or subtracted,
// then normalized one shift per cycle. Results truncate toward zero.
// Underflow gives +0. Overflow or a NaN/Inf input gives NAN.
module srsub_seq #(
  parameter int unsigned GUARD = 3,
  parameter logic [31:0] NAN   = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z
);

  // Working mantissa layout: [MW-1] carry, [MW-2] hidden bit,
  // [MW-3:GUARD] fraction, [GUARD-1:0] guard bits.
  localparam int unsigned MW = 25 + GUARD;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_ADDSUB = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;          // b with its sign already inverted
  logic [MW-1:0]   ml_q, ml_d;
  logic [MW-1:0]   ms_q, ms_d;
  logic [MW-1:0]   sum_q, sum_d;
  logic [7:0]      exp_q, exp_d;
  logic            sign_q, sign_d;
  logic            sub_q, sub_d;      // effective operation is a subtraction
  logic            short_q, short_d;  // result already known (zero/NaN shortcut)
  logic [31:0]     short_z_q, short_z_d;
  logic [31:0]     z_q, z_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  // Unpack signals used by the ALIGN step.
  logic [7:0]      ea, eb, el, es, ediff;
  logic [22:0]     mant_l, mant_s;
  logic            sl, ss, a_zero, b_zero, any_nan, a_ge_b;
  logic [MW-1:0]   ms_full, ms_shift;

  assign ea       = a_q[30:23];
  assign eb       = b_q[30:23];
  assign a_zero   = (ea == 8'd0);
  assign b_zero   = (eb == 8'd0);
  assign any_nan  = (ea == 8'hFF) || (eb == 8'hFF);
  // Exponent-then-mantissa magnitude compare; ties keep a as the larger.
  assign a_ge_b   = (a_q[30:0] >= b_q[30:0]);
  assign el       = a_ge_b ? ea : eb;
  assign es       = a_ge_b ? eb : ea;
  assign mant_l   = a_ge_b ? a_q[22:0] : b_q[22:0];
  assign mant_s   = a_ge_b ? b_q[22:0] : a_q[22:0];
  assign sl       = a_ge_b ? a_q[31] : b_q[31];
  assign ss       = a_ge_b ? b_q[31] : a_q[31];
  assign ediff    = el - es;
  assign ms_full  = {2'b01, mant_s, {GUARD{1'b0}}};
  assign ms_shift = (ediff > 8'(24 + GUARD)) ? {MW{1'b0}} : (ms_full >> ediff);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      ml_q        <= {MW{1'b0}};
      ms_q        <= {MW{1'b0}};
      sum_q       <= {MW{1'b0}};
      exp_q       <= 8'd0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      short_q     <= 1'b0;
      short_z_q   <= 32'd0;
      z_q         <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ml_q        <= ml_d;
      ms_q        <= ms_d;
      sum_q       <= sum_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      short_q     <= short_d;
      short_z_q   <= short_z_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and datapath logic: one FSM step per cycle.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ml_d      = ml_q;
    ms_d      = ms_q;
    sum_d     = sum_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    sub_d     = sub_q;
    short_d   = short_q;
    short_z_d = short_z_q;
    z_d       = z_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = {~b[31], b[30:0]};
          state_d = S_ALIGN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ALIGN: begin
        ml_d    = {2'b01, mant_l, {GUARD{1'b0}}};
        ms_d    = ms_shift;
        exp_d   = el;
        sign_d  = sl;
        sub_d   = (sl != ss);
        short_d = 1'b1;
        if (any_nan) begin
          short_z_d = NAN;
        end else if (a_zero && b_zero) begin
          short_z_d = 32'd0;
        end else if (b_zero) begin
          short_z_d = a_q;
        end else if (a_zero) begin
          short_z_d = b_q;
        end else begin
          short_z_d = 32'd0;
          short_d   = 1'b0;
        end
        state_d = S_ADDSUB;
      end
      S_ADDSUB: begin
        if (sub_q) begin
          sum_d = ml_q - ms_q;
        end else begin
          sum_d = ml_q + ms_q;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (short_q) begin
          z_d     = short_z_q;
          state_d = S_DONE;
        end else if (sum_q[MW-1]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_q + 8'd1;
          if (exp_q == 8'd254) begin
            z_d     = NAN;
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end else if (sum_q == {MW{1'b0}}) begin
          z_d     = 32'd0;
          state_d = S_DONE;
        end else if (!sum_q[MW-2]) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 8'd1;
          if (exp_q == 8'd1) begin
            z_d     = 32'd0;
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end else begin
          z_d     = {sign_q, exp_q, sum_q[22+GUARD:GUARD]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;

endmodule

// File: tb/tb_srsub_seq.sv
// Directed, table-driven bench for srsub_seq with hand-computed results.
module tb_srsub_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;

  int errors = 0;
  int checks = 0;

  srsub_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation; return result and accept-to-out_valid latency.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] zr, output int lat);
    lat = 0;
    zr  = 32'hDEADBEEF;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      check("busy_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    zr = z;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("after_ready_out_valid", {31'd0, out_valid}, 32'd0);
    check("after_ready_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] zr;
    int lat;

    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 3,  "3_minus_1"};
    vecs[1]  = '{32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 27, "cancel_24_shifts"};
    vecs[2]  = '{32'h40490FDB, 32'h40490FDB, 32'h00000000, 3,  "pi_minus_pi"};
    vecs[3]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 4,  "1_minus_neg1_carry"};
    vecs[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFFFFFFFF, 3,  "overflow_nan"};
    vecs[5]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 3,  "a_zero"};
    vecs[6]  = '{32'h3F800000, 32'h00000000, 32'h3F800000, 3,  "b_zero"};
    vecs[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, 3,  "both_zero"};
    vecs[8]  = '{32'h7F800000, 32'h3F800000, 32'hFFFFFFFF, 3,  "inf_input"};
    vecs[9]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 4,  "1_minus_2_neg"};
    vecs[10] = '{32'h3F800000, 32'h30800000, 32'h3F800000, 3,  "ediff_30_dropped"};
    vecs[11] = '{32'h3F800000, 32'h32800000, 32'h3F7FFFFF, 4,  "ediff_26_truncate"};
    vecs[12] = '{32'h3FC00000, 32'hBFC00000, 32'h40400000, 4,  "1p5_plus_1p5"};
    vecs[13] = '{32'h00800000, 32'h00C00000, 32'h00000000, 3,  "underflow_zero"};
    vecs[14] = '{32'h3F800000, 32'h7FC00000, 32'hFFFFFFFF, 3,  "nan_input"};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'd0;
    b         = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_z", z, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(zr, lat);
      check({vecs[i].name, "_z"}, zr, vecs[i].z);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      release_result();
    end

    // Backpressure: result and flags held while out_ready is low
    start_op(32'h40400000, 32'h3F800000);
    wait_result(zr, lat);
    in_valid = 1'b1;
    a = 32'h3F800000;
    b = 32'hBF800000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_z_held", z, 32'h40000000);
      check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_result();

    // Reset in the middle of a long normalization
    start_op(32'h3F800000, 32'h3F7FFFFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd0);
    check("midreset_z", z, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("after_reset_out_valid", {31'd0, out_valid}, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("aborted_op_no_result", 32'(seen), 32'd0);
    end

    // Recovery after the abort
    start_op(32'h40400000, 32'h3F800000);
    wait_result(zr, lat);
    check("recover_z", zr, 32'h40000000);
    check("recover_lat", 32'(lat), 32'd3);
    release_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
